// File: rtl/alu_op_sequencer_if.sv
// Request/response handshake bundle between a requester and alu_op_sequencer.
`timescale 1ns/1ps
interface alu_op_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       opcode;
   logic [WIDTH-1:0] a_in;
   logic [WIDTH-1:0] b_in;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             zero;
   logic             err;

   modport master (
      output in_valid, opcode, a_in, b_in, out_ready,
      input  in_ready, out_valid, result, zero, err
   );

   modport slave (
      input  in_valid, opcode, a_in, b_in, out_ready,
      output in_ready, out_valid, result, zero, err
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// Issues one operation to a bank of combinational function units, waits a
// programmable settle window, captures the OR-combined result and hands it out.
`timescale 1ns/1ps
module alu_op_sequencer #(
   parameter int WIDTH         = 8,
   parameter int NUM_OPS       = 8,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   alu_op_sequencer_if.slave    bus,
   output logic [WIDTH-1:0]     operand1,
   output logic [WIDTH-1:0]     operand2,
   output logic [NUM_OPS-1:0]   select,
   input  logic [WIDTH-1:0]     fu_result
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic [3:0] NUM_OPS_W   = 4'(NUM_OPS);

   state_t             state_reg, state_next;
   logic [2:0]         op_reg;
   logic [3:0]         cnt_reg;
   logic [WIDTH-1:0]   operand1_reg, operand2_reg;
   logic [WIDTH-1:0]   result_reg;
   logic               zero_reg, err_reg;
   logic               illegal;
   logic               in_ready_int, out_valid_int;
   logic [NUM_OPS-1:0] sel_decode, select_int;

   // Opcodes without a wired unit decode to no select bit at all.
   assign illegal = ({1'b0, op_reg} >= NUM_OPS_W);

   for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_dec
      assign sel_decode[gi] = (op_reg == 3'(gi));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next    = state_reg;
      in_ready_int  = 1'b0;
      out_valid_int = 1'b0;
      select_int    = '0;
      case (state_reg)
         IDLE: begin
            in_ready_int = 1'b1;
            if (bus.in_valid) state_next = ISSUE;
         end
         ISSUE: begin
            select_int = sel_decode;
            if (cnt_reg == 4'd0) state_next = DONE;
         end
         DONE: begin
            out_valid_int = 1'b1;
            if (bus.out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_reg       <= '0;
         cnt_reg      <= '0;
         operand1_reg <= '0;
         operand2_reg <= '0;
         result_reg   <= '0;
         zero_reg     <= 1'b0;
         err_reg      <= 1'b0;
      end else if (state_reg == IDLE && bus.in_valid) begin
         op_reg       <= bus.opcode;
         operand1_reg <= bus.a_in;
         operand2_reg <= bus.b_in;
         cnt_reg      <= SETTLE_LOAD;
      end else if (state_reg == ISSUE) begin
         // fu_result only matters on the final edge of the settle window.
         if (cnt_reg == 4'd0) begin
            result_reg <= illegal ? '0 : fu_result;
            zero_reg   <= illegal || (fu_result == '0);
            err_reg    <= illegal;
         end else begin
            cnt_reg <= cnt_reg - 4'd1;
         end
      end
   end

   assign operand1      = operand1_reg;
   assign operand2      = operand2_reg;
   assign select        = select_int;
   assign bus.in_ready  = in_ready_int;
   assign bus.out_valid = out_valid_int;
   assign bus.result    = result_reg;
   assign bus.zero      = zero_reg;
   assign bus.err       = err_reg;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Drives two sequencer instances (settle 1 / 8 units and settle 3 / 4 units)
// against a model function-unit bank, checking timing and captured results.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Stimulus goes to one DUT at a time; which=0 -> dut_a, which=1 -> dut_b.
   logic       which;
   logic       in_valid, out_ready;
   logic [2:0] opcode;
   logic [7:0] a_in, b_in;
   logic [7:0] noise;

   alu_op_sequencer_if #(.WIDTH(8)) ifa ();
   alu_op_sequencer_if #(.WIDTH(8)) ifb ();

   logic [7:0] op1_a, op2_a, fu_a, op1_b, op2_b, fu_b;
   logic [7:0] sel_a;
   logic [3:0] sel_b;

   assign ifa.in_valid  = in_valid & ~which;
   assign ifb.in_valid  = in_valid & which;
   assign ifa.out_ready = which ? 1'b1 : out_ready;
   assign ifb.out_ready = which ? out_ready : 1'b1;
   assign ifa.opcode = opcode;
   assign ifb.opcode = opcode;
   assign ifa.a_in = a_in;
   assign ifb.a_in = a_in;
   assign ifa.b_in = b_in;
   assign ifb.b_in = b_in;

   alu_op_sequencer #(.WIDTH(8), .NUM_OPS(8), .SETTLE_CYCLES(1)) dut_a (
      .clk(clk), .rst(rst), .bus(ifa), .operand1(op1_a), .operand2(op2_a),
      .select(sel_a), .fu_result(fu_a)
   );
   alu_op_sequencer #(.WIDTH(8), .NUM_OPS(4), .SETTLE_CYCLES(3)) dut_b (
      .clk(clk), .rst(rst), .bus(ifb), .operand1(op1_b), .operand2(op2_b),
      .select(sel_b), .fu_result(fu_b)
   );

   function automatic logic [7:0] unit_out(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return a ^ b;
         3'd3: return a + b;
         3'd4: return a - b;
         3'd5: return ~(a & b);
         3'd6: return ~(a | b);
         default: return ~(a ^ b);
      endcase
   endfunction

   // Function-unit bank: disabled units output 0; when nothing is selected the
   // bus carries junk so a missing force-to-zero on illegal opcodes shows up.
   always_comb begin
      fu_a = '0;
      for (int i = 0; i < 8; i++) if (sel_a[i]) fu_a = fu_a | unit_out(3'(i), op1_a, op2_a);
      if (sel_a == '0) fu_a = noise;
   end
   always_comb begin
      fu_b = '0;
      for (int i = 0; i < 4; i++) if (sel_b[i]) fu_b = fu_b | unit_out(3'(i), op1_b, op2_b);
      if (sel_b == '0) fu_b = noise;
   end

   logic       o_in_ready, o_out_valid, o_zero, o_err;
   logic [7:0] o_result, o_select, o_op1, o_op2;
   assign o_in_ready  = which ? ifb.in_ready  : ifa.in_ready;
   assign o_out_valid = which ? ifb.out_valid : ifa.out_valid;
   assign o_result    = which ? ifb.result    : ifa.result;
   assign o_zero      = which ? ifb.zero      : ifa.zero;
   assign o_err       = which ? ifb.err       : ifa.err;
   assign o_select    = which ? {4'b0, sel_b} : sel_a;
   assign o_op1       = which ? op1_b : op1_a;
   assign o_op2       = which ? op2_b : op2_a;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // One full transaction with out_ready=1, started right after an edge in IDLE.
   // Checks the per-cycle select, capture latency, result and return to IDLE.
   task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic ez, input logic ee);
      int         settle;
      int         nops;
      logic [7:0] exp_sel;
      settle  = which ? 3 : 1;
      nops    = which ? 4 : 8;
      exp_sel = (int'(op) < nops) ? (8'b1 << op) : 8'h00;
      chk("idle_ready", {31'b0, o_in_ready}, 32'd1);
      opcode = op; a_in = a; b_in = b; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int c = 0; c < settle; c++) begin
         chk("issue_sel", {23'b0, o_out_valid, o_select}, {24'b0, exp_sel});
         chk("issue_ready", {31'b0, o_in_ready}, 32'd0);
         if (c < settle - 1) begin @(posedge clk); #1; end
      end
      @(posedge clk); #1;
      chk("done_valid_sel", {23'b0, o_out_valid, o_select}, {23'b0, 1'b1, 8'h00});
      chk("done_result", {22'b0, o_err, o_zero, o_result}, {22'b0, ee, ez, er});
      chk("operands", {16'b0, o_op1, o_op2}, {16'b0, a, b});
      $display("op which=%0d opcode=%0d a=%h b=%h -> result=%h zero=%0b err=%0b",
               which, op, a, b, o_result, o_zero, o_err);
      @(posedge clk); #1;
      chk("back_idle", {30'b0, o_out_valid, o_in_ready}, 32'd1);
   endtask

   typedef struct {
      logic       w;
      logic [2:0] op;
      logic [7:0] a, b, er;
      logic       ez, ee;
   } vec_t;

   vec_t vecs[16];

   initial begin
      vecs[0]  = '{1'b0, 3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 3'd0, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
      vecs[2]  = '{1'b0, 3'd2, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0};
      vecs[3]  = '{1'b0, 3'd3, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0};
      vecs[4]  = '{1'b0, 3'd3, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0};
      vecs[5]  = '{1'b0, 3'd4, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
      vecs[6]  = '{1'b0, 3'd5, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b0};
      vecs[7]  = '{1'b0, 3'd6, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
      vecs[8]  = '{1'b0, 3'd7, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0};
      vecs[9]  = '{1'b1, 3'd0, 8'hF0, 8'h0F, 8'h00, 1'b1, 1'b0};
      vecs[10] = '{1'b1, 3'd3, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
      vecs[11] = '{1'b1, 3'd6, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1};
      vecs[12] = '{1'b1, 3'd4, 8'hFF, 8'hFF, 8'h00, 1'b1, 1'b1};
      vecs[13] = '{1'b1, 3'd7, 8'h01, 8'h02, 8'h00, 1'b1, 1'b1};
      vecs[14] = '{1'b1, 3'd2, 8'h3C, 8'h3C, 8'h00, 1'b1, 1'b0};
      vecs[15] = '{1'b1, 3'd1, 8'hA5, 8'h0F, 8'hAF, 1'b0, 1'b0};

      rst = 1'b1; which = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      opcode = '0; a_in = '0; b_in = '0; noise = 8'h5A;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", {13'b0, o_in_ready, o_out_valid, o_zero, o_err, o_select, o_result},
          {13'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00});
      chk("reset_operands", {16'b0, o_op1, o_op2}, 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 16; i++) begin
         which = vecs[i].w;
         #1;
         do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].er, vecs[i].ez, vecs[i].ee);
      end

      // Reset in the middle of the settle window on the 3-cycle instance.
      which = 1'b1;
      opcode = 3'd2; a_in = 8'h0F; b_in = 8'hF3; in_valid = 1'b1;
      @(posedge clk); #1;
      chk("pre_rst_sel", {24'b0, o_select}, 32'h04);
      rst = 1'b1;
      #1;
      chk("rst_mid_issue", {14'b0, o_in_ready, o_out_valid, o_select, o_result},
          {14'b0, 1'b1, 1'b0, 8'h00, 8'h00});
      @(posedge clk); #1;
      chk("rst_discard", {8'b0, o_select, o_op1, o_op2}, 32'd0);
      in_valid = 1'b0;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_rst_idle", {30'b0, o_out_valid, o_in_ready}, 32'd1);
      do_op(3'd1, 8'h30, 8'h03, 8'h33, 1'b0, 1'b0);

      // Backpressure on the 1-cycle instance while fu_result and in_valid wiggle.
      which = 1'b0;
      #1;
      opcode = 3'd1; a_in = 8'h3C; b_in = 8'hC3; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk("bp_enter", {23'b0, o_out_valid, o_result}, {23'b0, 1'b1, 8'hFF});
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         noise = ~noise ^ 8'(i);
         a_in = 8'(i);
         opcode = 3'(i);
         @(posedge clk); #1;
         chk("bp_hold", {13'b0, o_in_ready, o_out_valid, o_zero, o_err, o_select, o_result},
             {13'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'hFF});
         chk("bp_operands", {16'b0, o_op1, o_op2}, {16'b0, 8'h3C, 8'hC3});
         $display("stall cycle %0d result=%h in_ready=%0b", i, o_result, o_in_ready);
      end
      in_valid = 1'b0; out_ready = 1'b1; noise = 8'h5A;
      @(posedge clk); #1;
      chk("bp_release", {30'b0, o_out_valid, o_in_ready}, 32'd1);

      // Back-to-back stream against the model, alternating instances.
      for (int i = 0; i < 16; i++) begin
         logic [2:0] rop;
         logic [7:0] ra, rb, rr;
         logic       rill;
         which = i[0];
         #1;
         rop  = 3'($urandom_range(0, 7));
         ra   = 8'($urandom);
         rb   = 8'($urandom);
         rill = which && (rop >= 3'd4);
         rr   = rill ? 8'h00 : unit_out(rop, ra, rb);
         do_op(rop, ra, rb, rr, (rr == 8'h00), rill);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running want finished");
      $fatal(1, "timeout");
   end
endmodule
